mem_req_arbiter: RTL and testbench

- Shares one downstream memory read-request channel between NrReq upstream requesters (e.g. I-cache refill and D-cache miss unit); sits in front of the AXI/NoC adapter.
- Grants round-robin and tags each request with a transaction ID carrying the requester index.
- Tracks outstanding transactions per requester, capped at MaxOutstanding; routes responses back by ID.
- Provides a flush/drain sequence that stops granting and waits for all outstanding transactions to retire.

---
 rtl/mem_req_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Shares one downstream read-request channel between NrReq requesters, tracking per-requester
// outstanding counts and routing responses by ID. Define MEM_ARB_FIXED_PRIO_EN for fixed priority.
module mem_req_arbiter #(
    parameter int NrReq          = 2,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int TidWidth       = 4,
    parameter int MaxOutstanding = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NrReq-1:0]           req_valid_i,
    output logic [NrReq-1:0]           req_ready_o,
    input  logic [NrReq*AddrWidth-1:0] req_addr_i,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [AddrWidth-1:0]       mem_req_addr_o,
    output logic [TidWidth-1:0]        mem_req_tid_o,
    input  logic                       mem_rsp_valid_i,
    input  logic [TidWidth-1:0]        mem_rsp_tid_i,
    input  logic [DataWidth-1:0]       mem_rsp_data_i,
    output logic [NrReq-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]       rsp_data_o,
    output logic                       rsp_err_o,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic                       busy_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_e;

    state_e                         state_q, state_d;
    logic [IdxW-1:0]                gnt_idx_q, gnt_idx_d;
    logic                           mem_valid_q, mem_valid_d;
    logic [AddrWidth-1:0]           addr_q, addr_d;
    logic [TidWidth-1:0]            tid_q, tid_d;
    logic [NrReq-1:0][CntW-1:0]     cnt_q, cnt_d;
    logic [NrReq-1:0]               rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]           rsp_data_q, rsp_data_d;
    logic                           rsp_err_q, rsp_err_d;
    logic                           flush_done_q, flush_done_d;
    logic                           flush_seen_q, flush_seen_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]                ptr_q, ptr_d;
`endif

    logic [NrReq-1:0] eligible;
    logic             sel_found;
    logic [IdxW-1:0]  sel_idx;
    logic             can_grant;
    logic             hs;
    logic             rsp_ok;
    logic [IdxW-1:0]  rsp_idx;

    always_comb begin
        for (int k = 0; k < NrReq; k++) begin
            eligible[k] = req_valid_i[k] && (cnt_q[k] < CntW'(MaxOutstanding));
        end
    end

    // Scan downward so the last hit is the first eligible index in priority order.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NrReq - 1; i >= 0; i--) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
`else
            if (eligible[(int'(ptr_q) + i) % NrReq]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'((int'(ptr_q) + i) % NrReq);
            end
`endif
        end
    end

    assign can_grant = (state_q == IDLE) && !flush_i && sel_found;
    assign hs        = (state_q == HOLD) && mem_req_ready_i;
    assign rsp_idx   = mem_rsp_tid_i[IdxW-1:0];
    assign rsp_ok    = mem_rsp_valid_i && (32'(mem_rsp_tid_i) < NrReq) && (cnt_q[rsp_idx] != '0);

    // A grant and a response to the same requester in one cycle cancel out.
    always_comb begin
        for (int k = 0; k < NrReq; k++) begin
            cnt_d[k] = cnt_q[k]
                     + CntW'(hs && (gnt_idx_q == IdxW'(k)))
                     - CntW'(rsp_ok && (rsp_idx == IdxW'(k)));
        end
        rsp_valid_d = rsp_ok ? (NrReq'(1) << rsp_idx) : '0;
        rsp_data_d  = rsp_ok ? mem_rsp_data_i : rsp_data_q;
        rsp_err_d   = mem_rsp_valid_i && !rsp_ok;
    end

    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        mem_valid_d  = mem_valid_q;
        addr_d       = addr_q;
        tid_d        = tid_q;
        flush_done_d = 1'b0;
        // A completed flush is not repeated until flush_i drops.
        flush_seen_d = flush_seen_q && flush_i;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (flush_i && !flush_seen_q) begin
                    state_d = DRAIN;
                end else if (can_grant) begin
                    state_d     = HOLD;
                    mem_valid_d = 1'b1;
                    gnt_idx_d   = sel_idx;
                    addr_d      = req_addr_i[sel_idx*AddrWidth +: AddrWidth];
                    tid_d       = TidWidth'(sel_idx);
                end
            end
            HOLD: begin
                if (mem_req_ready_i) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    ptr_d = (int'(gnt_idx_q) == NrReq - 1) ? '0 : gnt_idx_q + 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                    flush_seen_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            gnt_idx_q    <= '0;
            mem_valid_q  <= 1'b0;
            addr_q       <= '0;
            tid_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            flush_done_q <= 1'b0;
            flush_seen_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            mem_valid_q  <= mem_valid_d;
            addr_q       <= addr_d;
            tid_q        <= tid_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            flush_done_q <= flush_done_d;
            flush_seen_q <= flush_seen_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    // The upstream handshake completes combinationally in the capture cycle.
    assign req_ready_o     = (can_grant && !flush_seen_q && !rst_i) ? (NrReq'(1) << sel_idx) : '0;
    assign mem_req_valid_o = mem_valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_tid_o   = tid_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_err_o       = rsp_err_q;
    assign flush_done_o    = flush_done_q;
    assign busy_o          = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NrReq=2, MaxOutstanding=7): grant order, outstanding cap,
// backpressure hold, flush/drain, illegal responses and mid-transaction reset.
module tb_mem_req_arbiter;
    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*AW-1:0]   req_addr;
    logic               mem_valid;
    logic               mem_ready;
    logic [AW-1:0]      mem_addr;
    logic [TW-1:0]      mem_tid;
    logic               mrsp_valid;
    logic [TW-1:0]      mrsp_tid;
    logic [DW-1:0]      mrsp_data;
    logic [NR-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               flush;
    logic               flush_done;
    logic               busy;

    int errors = 0;
    int checks = 0;

    mem_req_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .mem_req_valid_o (mem_valid),
        .mem_req_ready_i (mem_ready),
        .mem_req_addr_o  (mem_addr),
        .mem_req_tid_o   (mem_tid),
        .mem_rsp_valid_i (mrsp_valid),
        .mem_rsp_tid_i   (mrsp_tid),
        .mem_rsp_data_i  (mrsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .flush_i         (flush),
        .flush_done_o    (flush_done),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic [TW-1:0] tid, input logic [DW-1:0] data);
        mrsp_valid = 1'b1;
        mrsp_tid   = tid;
        mrsp_data  = data;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; mem_ready = 1'b0;
        mrsp_valid = 1'b0; mrsp_tid = '0; mrsp_data = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready, 0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_tid", mem_tid, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst flush_done", flush_done, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;

        // Round-robin alternation with responses three cycles after each handshake
        req_valid = 2'b11; req_addr = {64'h2000, 64'h1000}; mem_ready = 1'b1;
        #1 chk("A0 ready", req_ready, 2'b01); chk("A0 mvalid", mem_valid, 0); nxt;
        #1 chk("A1 mvalid", mem_valid, 1); chk("A1 tid", mem_tid, 0);
           chk("A1 addr", mem_addr, 64'h1000); chk("A1 ready", req_ready, 0); nxt;
        #1 chk("A2 ready", req_ready, 2'b10); nxt;
        #1 chk("A3 tid", mem_tid, 1); chk("A3 addr", mem_addr, 64'h2000); nxt;
        rsp(0, 64'hAA);
        #1 chk("A4 ready", req_ready, 2'b01); nxt;
        mrsp_valid = 1'b0;
        #1 chk("A5 rsp_valid", rsp_valid, 2'b01); chk("A5 rsp_data", rsp_data, 64'hAA);
           chk("A5 tid", mem_tid, 0); nxt;
        rsp(1, 64'hBB);
        #1 chk("A6 ready", req_ready, 2'b10); nxt;
        mrsp_valid = 1'b0;
        #1 chk("A7 rsp_valid", rsp_valid, 2'b10); chk("A7 rsp_data", rsp_data, 64'hBB);
           chk("A7 tid", mem_tid, 1); nxt;
        req_valid = 2'b00; rsp(0, 64'hCC);
        #1 chk("A8 ready", req_ready, 0); chk("A8 busy", busy, 1); nxt;
        mrsp_valid = 1'b0;
        #1 chk("A9 rsp_valid", rsp_valid, 2'b01); nxt;
        rsp(1, 64'hDD); nxt;
        mrsp_valid = 1'b0;
        #1 chk("A11 rsp_valid", rsp_valid, 2'b10); chk("A11 busy", busy, 0); nxt;

        // Requester 0 alone hits the outstanding cap of 7
        req_valid = 2'b01; req_addr[63:0] = 64'h4000;
        for (int g = 0; g < 7; g++) begin
            #1 chk("B grant ready", req_ready, 2'b01); nxt;
            #1 chk("B grant mvalid", mem_valid, 1); nxt;
        end
        #1 chk("B cap ready", req_ready, 0); chk("B cap busy", busy, 1); nxt;
        #1 chk("B cap ready2", req_ready, 0); chk("B cap mvalid", mem_valid, 0); nxt;
        rsp(0, 64'h55);
        #1 chk("B cap ready3", req_ready, 0); nxt;
        mrsp_valid = 1'b0;
        #1 chk("B rsp_valid", rsp_valid, 2'b01); chk("B 8th ready", req_ready, 2'b01); nxt;
        req_valid = 2'b00;
        #1 chk("B 8th mvalid", mem_valid, 1); chk("B 8th addr", mem_addr, 64'h4000); nxt;
        for (int i = 0; i < 7; i++) begin
            rsp(0, 64'(i)); nxt;
            mrsp_valid = 1'b0;
            #1 chk("B drain rsp_valid", rsp_valid, 2'b01); chk("B drain data", rsp_data, 64'(i)); nxt;
        end
        #1 chk("B idle busy", busy, 0); nxt;

        // Downstream backpressure: request held, count untouched until handshake
        req_valid = 2'b10; mem_ready = 1'b0;
        #1 chk("C0 ready", req_ready, 2'b10); nxt;
        req_valid = 2'b00; req_addr[127:64] = 64'h3333;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) rsp(1, 64'h77); else mrsp_valid = 1'b0;
            #1 chk("C hold mvalid", mem_valid, 1); chk("C hold addr", mem_addr, 64'h2000);
               chk("C hold tid", mem_tid, 1);
            if (i == 2) begin
                chk("C early rsp_err", rsp_err, 1);
                chk("C early rsp_valid", rsp_valid, 0);
                chk("C early rsp_data", rsp_data, 64'h6);
            end
            nxt;
        end
        mem_ready = 1'b1; mrsp_valid = 1'b0;
        #1 chk("C hs mvalid", mem_valid, 1); nxt;
        #1 chk("C post mvalid", mem_valid, 0); chk("C post busy", busy, 1); nxt;

        // Two more on requester 1 (three outstanding), then flush
        req_valid = 2'b10; req_addr[127:64] = 64'h2000;
        #1 chk("D g1 ready", req_ready, 2'b10); nxt;
        #1 chk("D g1 mvalid", mem_valid, 1); nxt;
        #1 chk("D g2 ready", req_ready, 2'b10); nxt;
        #1 chk("D g2 mvalid", mem_valid, 1); nxt;
        flush = 1'b1;
        #1 chk("D flush ready", req_ready, 0); nxt;
        #1 chk("D drain busy", busy, 1); chk("D drain done", flush_done, 0);
           chk("D drain ready", req_ready, 0); nxt;
        for (int i = 0; i < 3; i++) begin
            rsp(1, 64'hD0 + 64'(i)); nxt;
            mrsp_valid = 1'b0;
            #1 chk("D rsp_valid", rsp_valid, 2'b10); chk("D early done", flush_done, 0);
               chk("D no grant", req_ready, 0); nxt;
        end
        #1 chk("D done", flush_done, 1); chk("D busy", busy, 0); chk("D held ready", req_ready, 0); nxt;
        #1 chk("D done pulse", flush_done, 0); chk("D held ready2", req_ready, 0); nxt;
        req_valid = 2'b00; flush = 1'b0; nxt;
        flush = 1'b1;
        #1 chk("D2 idle done", flush_done, 0); nxt;
        #1 chk("D2 entry done", flush_done, 0); chk("D2 busy", busy, 1); nxt;
        #1 chk("D2 done", flush_done, 1); nxt;
        flush = 1'b0;

        // Illegal IDs: out of range, and zero count
        rsp(5, 64'hEE); nxt;
        rsp(0, 64'hEF);
        #1 chk("E tid5 err", rsp_err, 1); chk("E tid5 rsp_valid", rsp_valid, 0); nxt;
        mrsp_valid = 1'b0;
        #1 chk("E cnt0 err", rsp_err, 1); chk("E cnt0 rsp_valid", rsp_valid, 0);
           chk("E data kept", rsp_data, 64'hD2); nxt;
        #1 chk("E err clear", rsp_err, 0); chk("E busy", busy, 0); nxt;

        // Reset while HOLDing a grant to requester 1
        req_valid = 2'b01; mem_ready = 1'b1;
        #1 chk("F g0 ready", req_ready, 2'b01); nxt;
        nxt;
        req_valid = 2'b11; mem_ready = 1'b0;
        #1 chk("F g1 ready", req_ready, 2'b10); nxt;
        #1 chk("F hold tid", mem_tid, 1); chk("F hold mvalid", mem_valid, 1);
        rst = 1'b1;
        #1 chk("F rst mvalid", mem_valid, 0); chk("F rst ready", req_ready, 0);
           chk("F rst busy", busy, 0); chk("F rst tid", mem_tid, 0); chk("F rst addr", mem_addr, 0);
        nxt;
        rst = 1'b0;
        #1 chk("F first ready", req_ready, 2'b01); nxt;
        #1 chk("F first tid", mem_tid, 0); chk("F first mvalid", mem_valid, 1); nxt;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
